hazard_unit: RTL

- Generates the `stall` and `flush` inputs consumed by the instruction controller, closing the loop on that interface.
- Keeps a 2-deep scoreboard of in-flight register writers (EX, MEM slots) that mirrors the pipeline registers.
- Detects RAW hazards for the ID-stage instruction and sequences branch/jump flush slots after a PC redirect.
- Optionally produces EX-stage operand forwarding selects.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/hazard_unit_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 47 ++++
 rtl/hazard_unit.sv | 94 +++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width default, forwarding-select
// encodings and the in-flight writer entry tracked by the hazard scoreboard.
package pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] dest;
    logic                      is_load;
  } sb_entry_t;

  // $0 is hardwired, so a read of it can never depend on an in-flight writer
  function automatic logic src_match(input logic                      use_src,
                                     input logic [REG_ADDR_W_DEF-1:0] addr,
                                     input sb_entry_t                 slot);
    return use_src && slot.valid && (addr != '0) && (addr == slot.dest);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Controller <-> hazard unit signals: ID-stage operand/writer info and redirect
// request toward the hazard unit, stall/flush/forward selects back.
interface hazard_unit_if #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W_DEF
) ();

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic                  id_reg_write;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_is_load;
  logic                  pc_redirect;
  logic                  stall;
  logic                  flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_dest, id_is_load,
    output pc_redirect,
    input  stall, flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_dest, id_is_load,
    input  pc_redirect,
    output stall, flush, fwd_a, fwd_b
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// Two-slot (EX, MEM) shadow of the pipeline's register writers, with bubble
// insertion into EX and per-slot source-match flags for the ID instruction.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  sb_entry_t             i_id_entry,
  input  logic                  i_bubble,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic                  i_use_rs,
  input  logic                  i_use_rt,
  output logic                  o_rs_ex,
  output logic                  o_rs_mem,
  output logic                  o_rt_ex,
  output logic                  o_rt_mem,
  output logic                  o_ex_is_load
);

  sb_entry_t r_ex;
  sb_entry_t r_mem;

  // ID -> EX -> MEM shift; only the valid bits need reset
  always_ff @(posedge clk) begin
    r_ex.dest     <= i_id_entry.dest;
    r_ex.is_load  <= i_id_entry.is_load;
    r_mem.dest    <= r_ex.dest;
    r_mem.is_load <= r_ex.is_load;
    if (reset) begin
      r_ex.valid  <= 1'b0;
      r_mem.valid <= 1'b0;
    end else begin
      r_ex.valid  <= i_id_entry.valid && !i_bubble;
      r_mem.valid <= r_ex.valid;
    end
  end

  assign o_rs_ex      = src_match(i_use_rs, i_rs, r_ex);
  assign o_rs_mem     = src_match(i_use_rs, i_rs, r_mem);
  assign o_rt_ex      = src_match(i_use_rt, i_rt, r_ex);
  assign o_rt_mem     = src_match(i_use_rt, i_rt, r_mem);
  assign o_ex_is_load = r_ex.is_load;

endmodule

// File: rtl/hazard_unit.sv
// RAW stall and redirect flush generation for the ID stage. Optional feature
// macro HAZARD_FORWARD_EN adds registered EX forwarding selects (load-use stalls only).
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hif
);

  sb_entry_t  w_id_entry;
  logic       w_rs_ex, w_rs_mem, w_rt_ex, w_rt_mem, w_ex_is_load;
  logic       w_hazard, w_stall, w_flush, w_accept, w_bubble;
  logic [1:0] r_flush_cnt;

  assign w_id_entry.valid   = hif.id_reg_write && (hif.id_dest != '0);
  assign w_id_entry.dest    = hif.id_dest;
  assign w_id_entry.is_load = hif.id_is_load;

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .i_id_entry   (w_id_entry),
    .i_bubble     (w_bubble),
    .i_rs         (hif.id_rs),
    .i_rt         (hif.id_rt),
    .i_use_rs     (hif.id_use_rs),
    .i_use_rt     (hif.id_use_rt),
    .o_rs_ex      (w_rs_ex),
    .o_rs_mem     (w_rs_mem),
    .o_rt_ex      (w_rt_ex),
    .o_rt_mem     (w_rt_mem),
    .o_ex_is_load (w_ex_is_load)
  );

`ifdef HAZARD_FORWARD_EN
  assign w_hazard = (w_rs_ex || w_rt_ex) && w_ex_is_load;
`else
  logic w_unused_load;
  assign w_unused_load = w_ex_is_load;
  assign w_hazard = w_rs_ex || w_rs_mem || w_rt_ex || w_rt_mem;
`endif

  // A flushed ID instruction is dead, so it can neither stall nor redirect
  assign w_flush  = (r_flush_cnt != 2'd0);
  assign w_stall  = w_hazard && !w_flush;
  assign w_accept = hif.pc_redirect && !w_stall && !w_flush;
  assign w_bubble = w_stall || w_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= 2'd0;
    end else if (w_accept) begin
      r_flush_cnt <= 2'(FLUSH_SLOTS);
    end else if (r_flush_cnt != 2'd0) begin
      r_flush_cnt <= r_flush_cnt - 2'd1;
    end
  end

  assign hif.stall = w_stall;
  assign hif.flush = w_flush;

`ifdef HAZARD_FORWARD_EN
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  // The ID-time EX slot is in MEM when this instruction reaches EX, hence EX/MEM
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)  return FWD_EXMEM;
    if (mem_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_fwd_a <= fwd_sel(w_rs_ex, w_rs_mem);
      r_fwd_b <= fwd_sel(w_rt_ex, w_rt_mem);
    end
  end

  assign hif.fwd_a = r_fwd_a;
  assign hif.fwd_b = r_fwd_b;
`else
  assign hif.fwd_a = FWD_RF;
  assign hif.fwd_b = FWD_RF;
`endif

endmodule
